// File: rtl/sevenseg_page_scheduler.sv
// Purpose: time-shares an 8-digit hex panel between four 32-bit telemetry pages (auto/manual/alert).
// Latency: page_sel and disp_word change on the same edge; digit_en is registered one cycle after its inputs.
// Backpressure: none; button pulses are consumed in the cycle they arrive, or dropped when a higher-priority event wins.
module sevenseg_page_scheduler #(
    parameter int CLK_HZ        = 100_000_000,
    parameter int DWELL_MS      = 2000,
    parameter int ALERT_HOLD_MS = 3000,
    parameter int UPDATE_HZ     = 4,
    parameter int BLINK_HZ      = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] page_data,
    input  logic [3:0]   page_valid,
    input  logic [3:0]   page_alert,
    input  logic         btn_next,
    input  logic         btn_mode,
    input  logic         telem_enable,
    output logic [31:0]  disp_word,
    output logic [7:0]   digit_en,
    output logic [1:0]   page_sel,
    output logic         mode_manual,
    output logic         alert_active
);

    localparam int MS_DIV    = CLK_HZ / 1000;
    localparam int UPD_DIV   = CLK_HZ / UPDATE_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int MS_W      = (MS_DIV    > 1) ? $clog2(MS_DIV)    : 1;
    localparam int UPD_W     = (UPD_DIV   > 1) ? $clog2(UPD_DIV)   : 1;
    localparam int BLINK_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int DWELL_W   = $clog2(DWELL_MS + 1);
    localparam int HOLD_W    = $clog2(ALERT_HOLD_MS + 1);

    typedef enum logic [1:0] {
        ST_AUTO   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_ALERT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    state_t               ret_q, ret_d;
    logic [1:0]           page_sel_q, page_sel_d;
    logic [31:0]          disp_word_q, disp_word_d;
    logic [7:0]           digit_en_q, digit_en_d;
    logic [3:0]           page_alert_q, page_alert_d;
    logic [MS_W-1:0]      ms_cnt_q, ms_cnt_d;
    logic [UPD_W-1:0]     upd_cnt_q, upd_cnt_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;

    logic                 ms_tick;
    logic                 upd_tick;
    logic [3:0]           alert_rise;
    logic [1:0]           rise_idx;
    logic                 sel_load;
    logic [1:0]           nxt_page;

    // First valid page after p in round-robin order; p itself if no other page is valid.
    function automatic logic [1:0] next_valid(input logic [1:0] p, input logic [3:0] v);
        logic [1:0] r;
        logic [1:0] idx;
        r = p;
        for (int k = 3; k >= 1; k--) begin
            idx = p + 2'(k);
            if (v[idx]) begin
                r = idx;
            end
        end
        return r;
    endfunction

    // Free-running millisecond and snapshot prescalers plus the alert edge register.
    always_comb begin
        ms_cnt_d     = (ms_cnt_q == MS_W'(MS_DIV - 1)) ? '0 : ms_cnt_q + 1'b1;
        upd_cnt_d    = (upd_cnt_q == UPD_W'(UPD_DIV - 1)) ? '0 : upd_cnt_q + 1'b1;
        page_alert_d = page_alert;
    end

    assign ms_tick    = (ms_cnt_q == MS_W'(MS_DIV - 1));
    assign upd_tick   = (upd_cnt_q == UPD_W'(UPD_DIV - 1));
    assign alert_rise = page_alert & ~page_alert_q & page_valid;
    assign nxt_page   = next_valid(page_sel_q, page_valid);

    // Lowest-index rising alert wins among simultaneous rises.
    always_comb begin
        rise_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (alert_rise[i]) begin
                rise_idx = 2'(i);
            end
        end
    end

    // Page FSM: alert rise beats btn_mode beats btn_next; dwell/hold count ms ticks only.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        page_sel_d  = page_sel_q;
        dwell_d     = dwell_q;
        hold_d      = hold_q;
        blink_d     = blink_q;
        blink_cnt_d = '0;
        sel_load    = 1'b0;

        if (|alert_rise) begin
            // Entry or retarget; the saved return state survives a retarget.
            if (state_q != ST_ALERT) begin
                ret_d = state_q;
            end
            state_d    = ST_ALERT;
            page_sel_d = rise_idx;
            hold_d     = '0;
            blink_d    = 1'b1;
            sel_load   = 1'b1;
        end else begin
            case (state_q)
                ST_AUTO: begin
                    if (btn_mode) begin
                        state_d = ST_MANUAL;
                    end else if (btn_next) begin
                        page_sel_d = nxt_page;
                        dwell_d    = '0;
                        sel_load   = 1'b1;
                    end else if (ms_tick) begin
                        if (dwell_q == DWELL_W'(DWELL_MS - 1)) begin
                            page_sel_d = nxt_page;
                            dwell_d    = '0;
                            sel_load   = 1'b1;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end
                end
                ST_MANUAL: begin
                    if (btn_mode) begin
                        state_d = ST_AUTO;
                        dwell_d = '0;
                    end else if (btn_next) begin
                        page_sel_d = nxt_page;
                        sel_load   = 1'b1;
                    end
                end
                ST_ALERT: begin
                    // Blink phase toggles every BLINK_DIV cycles while alerted.
                    if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
                        blink_d = ~blink_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                    if (!page_valid[page_sel_q]) begin
                        state_d     = ret_q;
                        dwell_d     = '0;
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                    end else if (ms_tick) begin
                        if (hold_q == HOLD_W'(ALERT_HOLD_MS - 1)) begin
                            state_d     = ret_q;
                            dwell_d     = '0;
                            blink_d     = 1'b1;
                            blink_cnt_d = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_AUTO;
                end
            endcase
        end
    end

    // Snapshot: load on page change, else refresh on the update tick; stable otherwise.
    always_comb begin
        disp_word_d = disp_word_q;
        if (sel_load || upd_tick) begin
            disp_word_d = page_data[{page_sel_d, 5'd0} +: 32];
        end
    end

    // Digit enable mask from current state, one register stage.
    always_comb begin
        digit_en_d = 8'hFF;
        if (!telem_enable || !page_valid[page_sel_q]) begin
            digit_en_d = 8'h00;
        end else if (state_q == ST_ALERT) begin
            digit_en_d = {8{blink_q}};
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_AUTO;
            ret_q        <= ST_AUTO;
            page_sel_q   <= 2'd0;
            disp_word_q  <= 32'd0;
            digit_en_q   <= 8'h00;
            page_alert_q <= 4'd0;
            ms_cnt_q     <= '0;
            upd_cnt_q    <= '0;
            dwell_q      <= '0;
            hold_q       <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            page_sel_q   <= page_sel_d;
            disp_word_q  <= disp_word_d;
            digit_en_q   <= digit_en_d;
            page_alert_q <= page_alert_d;
            ms_cnt_q     <= ms_cnt_d;
            upd_cnt_q    <= upd_cnt_d;
            dwell_q      <= dwell_d;
            hold_q       <= hold_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
        end
    end

    assign disp_word    = disp_word_q;
    assign digit_en     = digit_en_q;
    assign page_sel     = page_sel_q;
    assign alert_active = (state_q == ST_ALERT);
    assign mode_manual  = (state_q == ST_MANUAL) || ((state_q == ST_ALERT) && (ret_q == ST_MANUAL));

endmodule

// File: tb/tb_sevenseg_page_scheduler.sv
// Purpose: directed bench for sevenseg_page_scheduler with hand-computed expectations.
// Latency: 1 ms = 10 clk, dwell 50 clk, alert hold 80 clk, snapshot every 100 clk, blink every 10 clk.
// Backpressure: not applicable; inputs are driven 1 time unit after each rising edge.
module tb_sevenseg_page_scheduler;

    localparam logic [31:0] D0  = 32'hA0A0_0000;
    localparam logic [31:0] D1  = 32'hB1B1_1111;
    localparam logic [31:0] D2  = 32'hC2C2_2222;
    localparam logic [31:0] D3  = 32'hD3D3_3333;
    localparam logic [31:0] NEW = 32'h5EED_3003;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  pd [4];
    logic [127:0] page_data;
    logic [3:0]   page_valid;
    logic [3:0]   page_alert;
    logic         btn_next;
    logic         btn_mode;
    logic         telem_enable;
    logic [31:0]  disp_word;
    logic [7:0]   digit_en;
    logic [1:0]   page_sel;
    logic         mode_manual;
    logic         alert_active;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    assign page_data = {pd[3], pd[2], pd[1], pd[0]};

    always #5 clk = ~clk;

    sevenseg_page_scheduler #(
        .CLK_HZ(10_000),
        .DWELL_MS(5),
        .ALERT_HOLD_MS(8),
        .UPDATE_HZ(100),
        .BLINK_HZ(500)
    ) dut (
        .clk(clk),
        .rst(rst),
        .page_data(page_data),
        .page_valid(page_valid),
        .page_alert(page_alert),
        .btn_next(btn_next),
        .btn_mode(btn_mode),
        .telem_enable(telem_enable),
        .disp_word(disp_word),
        .digit_en(digit_en),
        .page_sel(page_sel),
        .mode_manual(mode_manual),
        .alert_active(alert_active)
    );

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            #1;
        end
    endtask

    // Leaves the bench just after an edge such that the next edge carries an ms tick.
    task automatic align_ms();
        while (cyc % 10 != 9) step(1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] exp_seq [3];
        exp_seq = '{2'd1, 2'd3, 2'd0};

        rst = 1'b1;
        pd[0] = D0; pd[1] = D1; pd[2] = D2; pd[3] = D3;
        page_valid = 4'b1011;
        page_alert = 4'b0000;
        btn_next = 1'b0;
        btn_mode = 1'b0;
        telem_enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_page_sel", 32'(page_sel), 32'd0);
        check("rst_disp_word", disp_word, 32'd0);
        check("rst_digit_en", 32'(digit_en), 32'h00);
        check("rst_mode_manual", 32'(mode_manual), 32'd0);
        check("rst_alert_active", 32'(alert_active), 32'd0);
        rst = 1'b0;
        cyc = 0;

        // Rotation 0 -> 1 -> 3 -> 0 every 50 clk with snapshot on the same edge.
        step(1);
        check("rot_digit_en_on", 32'(digit_en), 32'hFF);
        step(48);
        check("rot_hold_p0", 32'(page_sel), 32'd0);
        step(1);
        check("rot_p1", 32'(page_sel), 32'd1);
        check("rot_p1_word", disp_word, D1);
        step(49);
        check("rot_hold_p1", 32'(page_sel), 32'd1);
        step(1);
        check("rot_p3", 32'(page_sel), 32'd3);
        check("rot_p3_word", disp_word, D3);
        step(50);
        check("rot_p0", 32'(page_sel), 32'd0);
        check("rot_p0_word", disp_word, D0);

        // Manual mode: three button presses, then idle.
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        check("man_mode", 32'(mode_manual), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(19);
            btn_next = 1'b1;
            step(1);
            btn_next = 1'b0;
            check("man_advance", 32'(page_sel), 32'(exp_seq[i]));
        end
        step(200);
        check("man_idle_page", 32'(page_sel), 32'd0);
        check("man_idle_word", disp_word, D0);
        check("man_idle_mode", 32'(mode_manual), 32'd1);

        // Preemption: alerts 2 and 3 rise together; lowest index wins.
        page_valid = 4'b1111;
        align_ms();
        page_alert = 4'b1100;
        step(1);
        check("pre_page", 32'(page_sel), 32'd2);
        check("pre_active", 32'(alert_active), 32'd1);
        check("pre_word", disp_word, D2);
        step(10);
        check("pre_blink_on", 32'(digit_en), 32'hFF);
        step(1);
        check("pre_blink_off", 32'(digit_en), 32'h00);
        step(10);
        check("pre_blink_on2", 32'(digit_en), 32'hFF);
        step(58);
        check("pre_still_alert", 32'(alert_active), 32'd1);
        step(1);
        check("pre_exit", 32'(alert_active), 32'd0);
        check("pre_exit_manual", 32'(mode_manual), 32'd1);
        check("pre_exit_page", 32'(page_sel), 32'd2);
        step(1);
        check("pre_exit_digits", 32'(digit_en), 32'hFF);

        // Retarget at hold=4 ms, then abort when the held page loses validity.
        page_alert = 4'b0000;
        step(1);
        align_ms();
        page_alert = 4'b0100;
        step(1);
        check("rt_enter_p2", 32'(page_sel), 32'd2);
        step(49);
        page_alert = 4'b0110;
        step(1);
        check("rt_page", 32'(page_sel), 32'd1);
        check("rt_word", disp_word, D1);
        step(19);
        btn_next = 1'b1;
        step(1);
        btn_next = 1'b0;
        check("rt_btn_ignored", 32'(page_sel), 32'd1);
        step(10);
        check("rt_hold_restarted", 32'(alert_active), 32'd1);
        step(10);
        check("rt_before_abort", 32'(alert_active), 32'd1);
        page_valid = 4'b1101;
        step(1);
        check("rt_abort", 32'(alert_active), 32'd0);
        check("rt_abort_manual", 32'(mode_manual), 32'd1);
        step(1);
        check("rt_abort_blank", 32'(digit_en), 32'h00);

        // Blanking while rotating, then no valid pages.
        page_valid = 4'b1011;
        page_alert = 4'b0000;
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        check("blk_auto", 32'(mode_manual), 32'd0);
        telem_enable = 1'b0;
        step(1);
        check("blk_digits_off", 32'(digit_en), 32'h00);
        step(60);
        check("blk_rotated", 32'(page_sel), 32'd3);
        check("blk_still_off", 32'(digit_en), 32'h00);
        telem_enable = 1'b1;
        page_valid = 4'b0000;
        step(1);
        check("nv_digits_off", 32'(digit_en), 32'h00);
        step(120);
        check("nv_frozen", 32'(page_sel), 32'd3);
        check("nv_still_off", 32'(digit_en), 32'h00);

        // Snapshot: data change mid-interval appears only on the 100-clk boundary.
        page_valid = 4'b1011;
        btn_mode = 1'b1;
        step(1);
        btn_mode = 1'b0;
        while (cyc % 100 != 30) step(1);
        pd[3] = NEW;
        step(69);
        check("snap_stable", disp_word, D3);
        step(1);
        check("snap_update", disp_word, NEW);

        // Reset during ALERT.
        page_alert = 4'b0001;
        step(1);
        check("rst_pre_alert", 32'(alert_active), 32'd1);
        step(5);
        rst = 1'b1;
        step(1);
        check("mid_rst_page_sel", 32'(page_sel), 32'd0);
        check("mid_rst_disp_word", disp_word, 32'd0);
        check("mid_rst_digit_en", 32'(digit_en), 32'h00);
        check("mid_rst_mode_manual", 32'(mode_manual), 32'd0);
        check("mid_rst_alert_active", 32'(alert_active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sevenseg_page_scheduler.md
Name: sevenseg_page_scheduler

Overview:
- Time-shares the 8-digit seven-segment telemetry panel between four 32-bit telemetry pages, for example ToF distance/status, IMU and I2C diagnostics.
- Rotates pages on a dwell timer or advances them on button pulses.
- Preempts rotation when any page raises an alert.
- Sits between the telemetry producers and the hex seven-segment engine.
- Drives the engine's eight hex nibbles and the digit_en mask.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
DWELL_MS, 2000, per-page dwell time in AUTO mode, in ms (>=1)
ALERT_HOLD_MS, 3000, time an alerted page is held, in ms (>=1)
UPDATE_HZ, 4, snapshot refresh rate of the displayed word (CLK_HZ/UPDATE_HZ integer)
BLINK_HZ, 2, blink toggle rate during ALERT (toggle every CLK_HZ/(2*BLINK_HZ) cycles)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
page_data  in  128  page i occupies [32i+31:32i]; nibble [31:28] maps to digit 7
page_valid  in  4  page i has live data
page_alert  in  4  level alert per page; the rising edge triggers preemption
btn_next  in  1  single-cycle pulse (debounced upstream): advance page
btn_mode  in  1  single-cycle pulse: toggle AUTO/MANUAL
telem_enable  in  1  0 blanks all digits
disp_word  out  32  nibbles to engine hex7..hex0
digit_en  out  8  per-digit enable to engine
page_sel  out  2  currently displayed page
mode_manual  out  1  1 in MANUAL, or when returning to MANUAL after an ALERT
alert_active  out  1  1 while in ALERT

Behaviour:
- Reset values:
  - state=AUTO, page_sel=0, disp_word=0, digit_en=0x00, mode_manual=0, alert_active=0.
  - All counters=0, alert edge register=0, blink phase=on.
- ms_tick: 1-cycle pulse every CLK_HZ/1000 clocks, from a free-running prescaler.
- Dwell and hold counters count ms_ticks only.
- next_valid(p): first index after p, in round-robin order 3->0, with page_valid set.
  - If no other page is valid, the result is p.
- States:
  - AUTO:
    - When the dwell count reaches DWELL_MS-1 and ms_tick fires: page_sel<=next_valid, dwell<=0.
    - btn_next: advance immediately, dwell<=0.
    - btn_mode: go to MANUAL.
  - MANUAL:
    - No timed advance.
    - btn_next advances the page.
    - btn_mode: go to AUTO with dwell<=0.
  - ALERT:
    - Entry: page_sel<=alerting index, hold<=0, return state saved, blink phase<=on.
    - Exit: after ALERT_HOLD_MS ms_ticks, return to the saved state with dwell<=0.
    - Early exit: if page_valid[page_sel] drops, exit the next cycle.
    - Buttons are ignored.
- Alert detection:
  - A page i alert is rise = page_alert[i] & ~page_alert_q[i] & page_valid[i].
  - Among simultaneous rises, the lowest index wins.
  - A rise during ALERT retargets to that page and restarts hold; the saved return state is kept.
  - A rise on the page already held restarts hold.
- Priority in one cycle: alert rise > btn_mode > btn_next.
  - When btn_mode and btn_next coincide, btn_next is dropped.
- Snapshot:
  - disp_word <= page_data of the new page on the same clock edge that page_sel changes.
  - Otherwise disp_word is reloaded from the current page every CLK_HZ/UPDATE_HZ clocks.
  - Between those loads disp_word is stable, with no live flicker.
- digit_en is registered, with 1-cycle latency from its inputs:
  - 0x00 if !telem_enable or !page_valid[page_sel].
  - Otherwise 0xFF, except in ALERT, where it is {8{blink}}.
  - blink starts on at ALERT entry and toggles per BLINK_HZ.
- All page_valid=0: page_sel holds, digits are blanked, the FSM still runs.
- Reset asserted mid-operation returns every output to its reset value on the next edge.

Test Plan:
(Simulation parameters for all scenarios: CLK_HZ=10_000 (1 ms = 10 clk), DWELL_MS=5, ALERT_HOLD_MS=8, UPDATE_HZ=100, BLINK_HZ=500.)
1. Rotation:
   - Stimulus: valid=4'b1011, AUTO, data distinct per page.
   - Required: page_sel sequence 0->1->3->0, changing every 50 clk; disp_word equals the new page's data on the same edge.
2. Manual mode:
   - Stimulus: btn_mode then 3 btn_next pulses, 20 clk apart.
   - Required: mode_manual=1; page_sel advances once per pulse; no change over 200 idle clk.
3. Preemption:
   - Stimulus: in MANUAL on page 0, page_alert[2] and [3] rise in the same cycle.
   - Required: page_sel=2, alert_active=1, digit_en toggles 0xFF/0x00 every 10 clk.
   - Required: after 80 clk, return to MANUAL with page_sel=2 retained and digit_en=0xFF.
4. Alert retarget/abort:
   - Stimulus: during ALERT on page 2, page_alert[1] rises at hold=4 ms.
   - Required: page_sel=1 and hold restarts (ALERT lasts 80 clk from the retarget).
   - Stimulus: then page_valid[1] drops.
   - Required: ALERT exits the next cycle.
5. Blanking and no-valid:
   - Stimulus: telem_enable=0.
   - Required: digit_en=0x00 one cycle later while page_sel keeps rotating.
   - Stimulus: page_valid=0.
   - Required: page_sel frozen, digit_en=0x00.
6. Snapshot and reset:
   - Stimulus: page data changes mid-dwell.
   - Required: disp_word updates only on a 100-clk boundary.
   - Stimulus: rst pulse during ALERT.
   - Required: all outputs reach their reset values on the next edge.
